gpio_input_conditioner: RTL and testbench

//  Sits directly downstream of the gpio block: consumes its gpio_read bus (raw, asynchronous pin levels)
//  and turns it into clean per-pin levels plus edge interrupts. Per bit: 2-flop synchroniser, counter

---
 rtl/gpio_input_conditioner_pkg.sv | 12 +
 rtl/gpio_debounce.sv | 45 ++++
 rtl/gpio_input_conditioner.sv | 51 +++++
 tb/tb_gpio_input_conditioner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_input_conditioner_pkg.sv
// rtl/gpio_input_conditioner_pkg.sv - shared defaults for the gpio input conditioner
package gpio_input_conditioner_pkg;

    // Default width tracks the upstream gpio instance; debounce depth is in synchronised cycles.
    localparam int GPIO_LENGTH_DEFAULT    = 4;
    localparam int GPIO_DB_CYCLES_DEFAULT = 4;

    function automatic int db_cnt_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one-bit synchroniser plus counter debouncer with accept strobe
module gpio_debounce
    import gpio_input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic sync,
    output logic accept
);

    localparam int CNT_W = db_cnt_width(DB_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // accept is true in the cycle whose edge commits sync2 into level
    assign accept = (sync2 != level) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign sync   = sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-pin debounce, edge events, sticky pending bits and irq
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int length    = GPIO_LENGTH_DEFAULT,
    parameter int DB_CYCLES = GPIO_DB_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [length-1:0] gpio_read,
    input  logic [length-1:0] irq_rise_en,
    input  logic [length-1:0] irq_fall_en,
    input  logic [length-1:0] irq_clear,
    output logic [length-1:0] pin_level,
    output logic [length-1:0] irq_pending,
    output logic              irq
);

    logic [length-1:0] sync_lvl;
    logic [length-1:0] accept;
    logic [length-1:0] rise_evt;
    logic [length-1:0] fall_evt;

    for (genvar i = 0; i < length; i++) begin : g_bit
        gpio_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (gpio_read[i]),
            .level (pin_level[i]),
            .sync  (sync_lvl[i]),
            .accept(accept[i])
        );
    end

    assign rise_evt = accept &  sync_lvl & irq_rise_en;
    assign fall_evt = accept & ~sync_lvl & irq_fall_en;

    // New events are OR'd in after the clear so a coincident event survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_pending <= '0;
        end else begin
            irq_pending <= (irq_pending & ~irq_clear) | rise_evt | fall_evt;
        end
    end

    assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - directed self-checking bench for gpio_input_conditioner
module tb_gpio_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] gpio_read;
    logic [3:0] irq_rise_en;
    logic [3:0] irq_fall_en;
    logic [3:0] irq_clear;
    logic [3:0] pin_level;
    logic [3:0] irq_pending;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_input_conditioner #(
        .length   (4),
        .DB_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_read  (gpio_read),
        .irq_rise_en(irq_rise_en),
        .irq_fall_en(irq_fall_en),
        .irq_clear  (irq_clear),
        .pin_level  (pin_level),
        .irq_pending(irq_pending),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        gpio_read = 4'b1111;
        irq_rise_en = 4'b1111;
        irq_fall_en = 4'b1111;
        irq_clear = 4'b0000;
        #1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pin_level !== 4'b0000 || irq_pending !== 4'b0000 || irq !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: pin_level=%b irq_pending=%b irq=%b, expected 0000 0000 0",
                         i, pin_level, irq_pending, irq);
            end
        end
        gpio_read = 4'b0000;
        irq_rise_en = 4'b0000;
        irq_fall_en = 4'b0000;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_rise_latency();
        irq_rise_en = 4'b0010;
        gpio_read = 4'b0010;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (e < 6) begin
                if (pin_level !== 4'b0000 || irq_pending !== 4'b0000 || irq !== 1'b0) begin
                    errors++;
                    $display("FAIL rise_latency edge %0d: pin_level=%b irq_pending=%b irq=%b, expected 0000 0000 0",
                             e, pin_level, irq_pending, irq);
                end
            end else begin
                if (pin_level !== 4'b0010 || irq_pending !== 4'b0010 || irq !== 1'b1) begin
                    errors++;
                    $display("FAIL rise_latency edge 6: pin_level=%b irq_pending=%b irq=%b, expected 0010 0010 1",
                             pin_level, irq_pending, irq);
                end
            end
        end
    endtask

    task automatic test_glitch();
        irq_rise_en = 4'b1111;
        gpio_read = 4'b0011;
        for (int i = 0; i < 3; i++) tick();
        gpio_read = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (pin_level !== 4'b0010 || irq_pending !== 4'b0010) begin
                errors++;
                $display("FAIL glitch cycle %0d: pin_level=%b irq_pending=%b, expected 0010 0010",
                         i, pin_level, irq_pending);
            end
        end
    endtask

    task automatic test_clear();
        irq_rise_en = 4'b0000;
        irq_clear = 4'b0010;
        tick();
        irq_clear = 4'b0000;
        checks++;
        if (irq_pending !== 4'b0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clear: irq_pending=%b irq=%b, expected 0000 0", irq_pending, irq);
        end
        irq_clear = 4'b0100;
        tick();
        irq_clear = 4'b0000;
        checks++;
        if (irq_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clear_zero_bit: irq_pending=%b, expected 0000", irq_pending);
        end
        irq_fall_en = 4'b0010;
        gpio_read = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pin_level !== 4'b0010) begin
            errors++;
            $display("FAIL fall_pre_accept: pin_level=%b, expected 0010", pin_level);
        end
        irq_clear = 4'b0010;
        tick();
        irq_clear = 4'b0000;
        checks++;
        if (pin_level !== 4'b0000 || irq_pending !== 4'b0010 || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: pin_level=%b irq_pending=%b irq=%b, expected 0000 0010 1",
                     pin_level, irq_pending, irq);
        end
        irq_fall_en = 4'b0000;
        irq_clear = 4'b1111;
        tick();
        irq_clear = 4'b0000;
        checks++;
        if (irq_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clear_all: irq_pending=%b, expected 0000", irq_pending);
        end
    endtask

    task automatic test_disabled_toggle();
        irq_rise_en = 4'b0000;
        irq_fall_en = 4'b0000;
        gpio_read = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pin_level !== 4'b0000) begin
            errors++;
            $display("FAIL disabled_pre_rise: pin_level=%b, expected 0000", pin_level);
        end
        tick();
        checks++;
        if (pin_level !== 4'b0100 || irq_pending !== 4'b0000) begin
            errors++;
            $display("FAIL disabled_rise: pin_level=%b irq_pending=%b, expected 0100 0000",
                     pin_level, irq_pending);
        end
        gpio_read = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (pin_level !== 4'b0000 || irq_pending !== 4'b0000) begin
            errors++;
            $display("FAIL disabled_fall: pin_level=%b irq_pending=%b, expected 0000 0000",
                     pin_level, irq_pending);
        end
    endtask

    task automatic test_multi_bit();
        irq_rise_en = 4'b1111;
        gpio_read = 4'b1011;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (pin_level !== 4'b1011 || irq_pending !== 4'b1011 || irq !== 1'b1) begin
            errors++;
            $display("FAIL multi_bit: pin_level=%b irq_pending=%b irq=%b, expected 1011 1011 1",
                     pin_level, irq_pending, irq);
        end
        irq_rise_en = 4'b0000;
        tick();
        checks++;
        if (irq_pending !== 4'b1011) begin
            errors++;
            $display("FAIL enable_drop_keeps: irq_pending=%b, expected 1011", irq_pending);
        end
        gpio_read = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (pin_level !== 4'b0000 || irq_pending !== 4'b1011) begin
            errors++;
            $display("FAIL multi_fall_no_en: pin_level=%b irq_pending=%b, expected 0000 1011",
                     pin_level, irq_pending);
        end
    endtask

    task automatic test_reset_mid_debounce();
        gpio_read = 4'b1000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (pin_level !== 4'b0000 || irq_pending !== 4'b0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pin_level=%b irq_pending=%b irq=%b, expected 0000 0000 0",
                     pin_level, irq_pending, irq);
        end
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (e < 6 && pin_level !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_latency edge %0d: pin_level=%b, expected 0000", e, pin_level);
            end else if (e == 6 && (pin_level !== 4'b1000 || irq_pending !== 4'b0000)) begin
                errors++;
                $display("FAIL post_reset_accept: pin_level=%b irq_pending=%b, expected 1000 0000",
                         pin_level, irq_pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_clear();
        test_disabled_toggle();
        test_multi_bit();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
